// File: rtl/round_timer_ctrl_if.sv
// Control/status bundle between the game FSM (master) and the round timer (slave).
// Carries the round control inputs and the timer's registered status outputs.
interface round_timer_ctrl_if #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned RND_W = 8
);
  logic             game_active;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [CNT_W-1:0] round_time;
  logic [CNT_W-1:0] remaining;
  logic             running;
  logic             expired;
  logic [RND_W-1:0] rounds;
  logic             warn;

  modport master (
    output game_active, start, pause, auto_reload, round_time,
    input  remaining, running, expired, rounds, warn
  );

  modport slave (
    input  game_active, start, pause, auto_reload, round_time,
    output remaining, running, expired, rounds, warn
  );
endinterface

// File: rtl/round_timer_ctrl.sv
// Prescaled round countdown timer with pause, abort, auto-reload and a saturating round counter.
// Optional feature: define ROUND_TIMER_WARN_EN to drive warn when few ticks remain.
module round_timer_ctrl #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned RND_W    = 8,
  parameter int unsigned WARN_TH  = 2
) (
  input logic               clk,
  input logic               rst_n,
  round_timer_ctrl_if.slave bus
);

  localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PresLast = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] RemOne   = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [RND_W-1:0] rounds_q, rounds_d;
  logic             expired_q, expired_d;
  logic             running_q, running_d;
  logic             warn_q, warn_d;

  logic             from_rest;
  logic [RND_W-1:0] rounds_sat;

  // Starting from IDLE/DONE begins a fresh series, so the round count restarts.
  assign from_rest  = (state_q == StIdle) || (state_q == StDone);
  assign rounds_sat = (&rounds_q) ? rounds_q : rounds_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    rounds_d  = rounds_q;
    expired_d = 1'b0;

    if (!bus.game_active) begin
      state_d = StIdle;
      presc_d = '0;
    end else if (bus.start) begin
      rem_d   = bus.round_time;
      presc_d = '0;
      if (bus.round_time == '0) begin
        state_d   = StDone;
        expired_d = 1'b1;
        rounds_d  = from_rest ? RND_W'(1) : rounds_sat;
      end else begin
        state_d = StRun;
        if (from_rest) rounds_d = '0;
      end
    end else if (bus.pause) begin
      if (state_q == StRun) state_d = StPaused;
    end else if ((state_q == StRun) || (state_q == StPaused)) begin
      // Leaving PAUSED counts this edge as an enabled cycle, so a pause costs exactly its length.
      state_d = StRun;
      if (presc_q == PresLast) begin
        presc_d = '0;
        if (rem_q <= RemOne) begin
          rem_d     = '0;
          expired_d = 1'b1;
          rounds_d  = rounds_sat;
          if (bus.auto_reload && (bus.round_time != '0)) begin
            rem_d = bus.round_time;
          end else begin
            state_d = StDone;
          end
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    running_d = (state_d == StRun) || (state_d == StPaused);
  end

`ifdef ROUND_TIMER_WARN_EN
  localparam logic [CNT_W-1:0] WarnTh = CNT_W'(WARN_TH);
  assign warn_d = running_d && (rem_d <= WarnTh) && (rem_d != '0);
`else
  assign warn_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      rem_q     <= '0;
      rounds_q  <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      rounds_q  <= rounds_d;
      expired_q <= expired_d;
      running_q <= running_d;
      warn_q    <= warn_d;
    end
  end

  assign bus.remaining = rem_q;
  assign bus.running   = running_q;
  assign bus.expired   = expired_q;
  assign bus.rounds    = rounds_q;
  assign bus.warn      = warn_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl: countdown, pause, auto-reload, abort, zero-length rounds,
// plus a second instance (PRESCALE=1, RND_W=2) for round-counter saturation.
module tb_round_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef ROUND_TIMER_WARN_EN
  localparam bit WarnEn = 1'b1;
`else
  localparam bit WarnEn = 1'b0;
`endif

  round_timer_ctrl_if #(.CNT_W(4), .RND_W(8)) bus_a ();
  round_timer_ctrl_if #(.CNT_W(4), .RND_W(2)) bus_b ();

  round_timer_ctrl #(.CNT_W(4), .PRESCALE(4), .RND_W(8), .WARN_TH(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  round_timer_ctrl #(.CNT_W(4), .PRESCALE(1), .RND_W(2), .WARN_TH(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int rem, input bit run, input bit exp_pulse,
                         input int rnd);
    bit exp_warn;
    exp_warn = WarnEn && run && (rem >= 1) && (rem <= 2);
    check({tag, ".remaining"}, 32'(bus_a.remaining), 32'(rem));
    check({tag, ".running"},   32'(bus_a.running),   32'(run));
    check({tag, ".expired"},   32'(bus_a.expired),   32'(exp_pulse));
    check({tag, ".rounds"},    32'(bus_a.rounds),    32'(rnd));
    check({tag, ".warn"},      32'(bus_a.warn),      32'(exp_warn));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.game_active = 1'b1;
    bus_a.start       = 1'b1;
    bus_a.pause       = 1'b0;
    bus_a.auto_reload = 1'b0;
    bus_a.round_time  = 4'd5;
    bus_b.game_active = 1'b1;
    bus_b.start       = 1'b0;
    bus_b.pause       = 1'b0;
    bus_b.auto_reload = 1'b1;
    bus_b.round_time  = 4'd1;
    rst_n = 1'b0;

    // Reset wins over a held start.
    step();
    step();
    check_a("reset", 0, 0, 0, 0);
    bus_a.start = 1'b0;
    rst_n = 1'b1;
    step();
    check_a("idle", 0, 0, 0, 0);

    // Plain countdown: 5 ticks of 4 cycles.
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    check_a("start", 5, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k < 20) check_a("count", 5 - k / 4, 1, 0, 0);
      else        check_a("expire", 0, 0, 1, 1);
    end
    step();
    check_a("done", 0, 0, 0, 1);

    // Pause of 7 cycles delays expiry by exactly 7 cycles.
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    check_a("start2", 5, 1, 0, 0);
    repeat (8) step();
    check_a("pre_pause", 3, 1, 0, 0);
    bus_a.pause = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check_a("paused", 3, 1, 0, 0);
    end
    bus_a.pause = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k < 12) check_a("resume", 3 - k / 4, 1, 0, 0);
      else        check_a("pause_exp", 0, 0, 1, 1);
    end

    // Auto-reload: expiry every 12 cycles, rounds counts up.
    bus_a.auto_reload = 1'b1;
    bus_a.round_time  = 4'd3;
    bus_a.start       = 1'b1;
    step();
    bus_a.start = 1'b0;
    check_a("ar_start", 3, 1, 0, 0);
    for (int k = 1; k <= 36; k++) begin
      step();
      if (k % 12 == 0) check_a("ar_exp", 3, 1, 1, k / 12);
      else             check_a("ar_cnt", 3 - (k % 12) / 4, 1, 0, k / 12);
    end

    // Abort at remaining=2: IDLE, value holds, no pulse.
    repeat (4) step();
    check_a("pre_abort", 2, 1, 0, 3);
    bus_a.game_active = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_a("abort", 2, 0, 0, 3);
    end
    bus_a.game_active = 1'b1;
    bus_a.auto_reload = 1'b0;
    bus_a.round_time  = 4'd5;
    bus_a.start       = 1'b1;
    step();
    bus_a.start = 1'b0;
    check_a("restart", 5, 1, 0, 0);

    // Start coinciding with a tick: reload wins, no decrement.
    repeat (3) step();
    check_a("pre_tick", 5, 1, 0, 0);
    bus_a.round_time = 4'd4;
    bus_a.start      = 1'b1;
    step();
    bus_a.start      = 1'b0;
    bus_a.round_time = 4'd9;
    check_a("start_on_tick", 4, 1, 0, 0);
    // Mid-round round_time change is ignored.
    repeat (15) step();
    check_a("mid_change", 1, 1, 0, 0);
    step();
    check_a("mid_exp", 0, 0, 1, 1);

    // Zero-length round: immediate expiry, no reload despite auto_reload.
    bus_a.auto_reload = 1'b1;
    bus_a.round_time  = 4'd0;
    bus_a.start       = 1'b1;
    step();
    bus_a.start = 1'b0;
    check_a("zero", 0, 0, 1, 1);
    step();
    check_a("zero_after", 0, 0, 0, 1);

    // Saturation with RND_W=2, PRESCALE=1: expiry every cycle.
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    check("sat_start.remaining", 32'(bus_b.remaining), 32'd1);
    check("sat_start.rounds", 32'(bus_b.rounds), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("sat.rounds", 32'(bus_b.rounds), 32'((k < 3) ? k : 3));
      check("sat.expired", 32'(bus_b.expired), 32'd1);
      check("sat.running", 32'(bus_b.running), 32'd1);
      check("sat.remaining", 32'(bus_b.remaining), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
